aline_receive_fsm: RTL and testbench

Receive-side counterpart of the A-line transmit state machine. After the transmitter reports `transmit_complete`, the block does three things in order. First, it waits a programmable blanking interval. Second, it acquires a fixed number of ADC samples from up to 8 channels and gates each channel in only after its own receive delay has elapsed. Third, it writes the per-sample channel sum into a small output FIFO that has a valid/ready handshake. It sits between the ADC capture logic and the A-line readout/host path.

---
 rtl/aline_receive_fsm_pkg.sv | 22 ++
 rtl/aline_rx_fifo.sv | 50 +++++
 rtl/aline_receive_fsm.sv | 150 +++++++++++++++
 tb/tb_aline_receive_fsm.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aline_receive_fsm_pkg.sv
// Shared types for the A-line receive path.
// State encodings and the channel-sum width rule.
package aline_receive_fsm_pkg;

  typedef enum logic [2:0] {
    RX_IDLE     = 3'd0,
    LOAD_DELAYS = 3'd1,
    WAIT_TX     = 3'd2,
    BLANK       = 3'd3,
    ACQUIRE     = 3'd4,
    DRAIN       = 3'd5,
    RX_DONE     = 3'd6
  } rx_state_t;

  function automatic int sum_width(
    input int sw,
    input int nc
  );
    return sw + $clog2(nc);
  endfunction

endpackage

// File: rtl/aline_rx_fifo.sv
// Show-ahead FIFO for summed A-line words.
// Output reads as zero whenever the FIFO is empty.
module aline_rx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             one_left
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic             rd_ok;
  logic             wr_ok;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign one_left = (count == (AW+1)'(1));
  assign rd_ok    = rd_en && !empty;
  // a pop in the same cycle frees the slot for a push
  assign wr_ok    = wr_en && (!full || rd_ok);
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/aline_receive_fsm.sv
// A-line receive sequencer: blank, gated channel sum,
// then drain through a valid/ready output FIFO.
module aline_receive_fsm
  import aline_receive_fsm_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int SAMPLE_WIDTH = 12,
  parameter int COUNT_WIDTH  = 16,
  parameter int FIFO_DEPTH   = 16,
  localparam int SUM_W = sum_width(SAMPLE_WIDTH, NUM_CHANNELS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                input_delay_data,
  input  logic [NUM_CHANNELS-1:0]             used_channels,
  input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] rx_delays,
  input  logic [COUNT_WIDTH-1:0]              rx_blank,
  input  logic [COUNT_WIDTH-1:0]              num_samples,
  input  logic                                transmit_complete,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] adc_data,
  input  logic                                adc_valid,
  input  logic                                aline_ready,
  output logic [SUM_W-1:0]                    aline_data,
  output logic                                aline_valid,
  output logic                                aline_last,
  output logic                                receive_in_progress,
  output logic                                receive_complete,
  output logic                                overflow
);

  rx_state_t state;

  logic [NUM_CHANNELS-1:0]             cfg_used;
  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] cfg_delays;
  logic [COUNT_WIDTH-1:0]              cfg_blank;
  logic [COUNT_WIDTH-1:0]              cfg_num;
  logic [COUNT_WIDTH-1:0]              blank_cnt;
  logic [COUNT_WIDTH-1:0]              samp_cnt;

  logic             push_q;
  logic             push_last;
  logic [SUM_W-1:0] push_data;
  logic [SUM_W-1:0] sum;

  logic [SUM_W:0] f_rd;
  logic           f_full;
  logic           f_empty;
  logic           f_one;
  logic           pop;

  assign aline_valid = !f_empty;
  assign pop         = aline_valid && aline_ready;
  assign aline_last  = f_rd[SUM_W];
  assign aline_data  = f_rd[SUM_W-1:0];

  // channel c joins once the sample index reaches its delay
  always_comb begin
    sum = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (cfg_used[c] &&
          samp_cnt >= cfg_delays[c*COUNT_WIDTH +: COUNT_WIDTH])
        sum = sum + {
          {(SUM_W-SAMPLE_WIDTH){adc_data[c*SAMPLE_WIDTH+SAMPLE_WIDTH-1]}},
          adc_data[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
        };
    end
  end

  aline_rx_fifo #(
    .WIDTH(SUM_W+1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_q),
    .wr_data ({push_last, push_data}),
    .rd_en   (aline_ready),
    .rd_data (f_rd),
    .full    (f_full),
    .empty   (f_empty),
    .one_left(f_one)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= RX_IDLE;
      cfg_used            <= '0;
      cfg_delays          <= '0;
      cfg_blank           <= '0;
      cfg_num             <= '0;
      blank_cnt           <= '0;
      samp_cnt            <= '0;
      push_q              <= 1'b0;
      push_last           <= 1'b0;
      push_data           <= '0;
      receive_in_progress <= 1'b0;
      receive_complete    <= 1'b0;
      overflow            <= 1'b0;
    end else begin
      push_q           <= 1'b0;
      receive_complete <= 1'b0;
      if (push_q && f_full && !pop) overflow <= 1'b1;
      unique case (state)
        RX_IDLE: begin
          if (input_delay_data) state <= LOAD_DELAYS;
        end
        LOAD_DELAYS: begin
          cfg_used   <= used_channels;
          cfg_delays <= rx_delays;
          cfg_blank  <= rx_blank;
          cfg_num    <= num_samples;
          overflow   <= 1'b0;
          state      <= WAIT_TX;
        end
        WAIT_TX: begin
          blank_cnt <= '0;
          samp_cnt  <= '0;
          if (transmit_complete) begin
            receive_in_progress <= 1'b1;
            state <= (cfg_blank == '0) ? ACQUIRE : BLANK;
          end
        end
        BLANK: begin
          if (blank_cnt == cfg_blank - 1'b1) state <= ACQUIRE;
          else blank_cnt <= blank_cnt + 1'b1;
        end
        ACQUIRE: begin
          if (samp_cnt == cfg_num) begin
            state <= DRAIN;
          end else if (adc_valid) begin
            push_q    <= 1'b1;
            push_data <= sum;
            push_last <= (samp_cnt == cfg_num - 1'b1);
            samp_cnt  <= samp_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!push_q && (f_empty || (f_one && pop))) begin
            receive_in_progress <= 1'b0;
            receive_complete    <= 1'b1;
            state               <= RX_DONE;
          end
        end
        RX_DONE: state <= RX_IDLE;
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aline_receive_fsm.sv
// Self-checking bench for aline_receive_fsm against
// a per-sample gated-sum reference model.
module tb_aline_receive_fsm;

  localparam int NC   = 8;
  localparam int SW   = 12;
  localparam int CW   = 16;
  localparam int FD   = 16;
  localparam int SUMW = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              input_delay_data = 1'b0;
  logic [NC-1:0]     used_channels = '0;
  logic [NC*CW-1:0]  rx_delays = '0;
  logic [CW-1:0]     rx_blank = '0;
  logic [CW-1:0]     num_samples = '0;
  logic              transmit_complete = 1'b0;
  logic [NC*SW-1:0]  adc_data = '0;
  logic              adc_valid = 1'b0;
  logic              aline_ready = 1'b0;
  logic [SUMW-1:0]   aline_data;
  logic              aline_valid;
  logic              aline_last;
  logic              receive_in_progress;
  logic              receive_complete;
  logic              overflow;

  always #5 clk = ~clk;

  aline_receive_fsm #(
    .NUM_CHANNELS(NC),
    .SAMPLE_WIDTH(SW),
    .COUNT_WIDTH (CW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .input_delay_data   (input_delay_data),
    .used_channels      (used_channels),
    .rx_delays          (rx_delays),
    .rx_blank           (rx_blank),
    .num_samples        (num_samples),
    .transmit_complete  (transmit_complete),
    .adc_data           (adc_data),
    .adc_valid          (adc_valid),
    .aline_ready        (aline_ready),
    .aline_data         (aline_data),
    .aline_valid        (aline_valid),
    .aline_last         (aline_last),
    .receive_in_progress(receive_in_progress),
    .receive_complete   (receive_complete),
    .overflow           (overflow)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  int rc_count, rc_cyc, first_valid_cyc, last_pop_cyc;
  int tc_cyc, first_adc_cyc;
  bit valid_seen;
  bit rnd_ready = 1'b0;

  logic [NC-1:0] m_used;
  int m_del[NC];
  int m_blank;
  int m_num;
  int smp[32][NC];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (aline_valid && !valid_seen) begin
        valid_seen = 1'b1;
        first_valid_cyc = cyc;
      end
      if (aline_valid && aline_ready) begin
        got.push_back({aline_last, aline_data});
        last_pop_cyc = cyc;
      end
      if (receive_complete) begin
        rc_count++;
        rc_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) aline_ready = ($urandom_range(0, 3) != 0);
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  // {last, 15-bit sum} for sample index s
  function automatic logic [15:0] exp_word(input int s);
    int acc;
    logic [31:0] a;
    acc = 0;
    for (int c = 0; c < NC; c++)
      if (m_used[c] && s >= m_del[c]) acc += smp[s][c];
    a = acc;
    return {(s == m_num - 1), a[14:0]};
  endfunction

  task automatic build_exp(input int keep);
    exp_q.delete();
    for (int s = 0; s < m_num && s < keep; s++)
      exp_q.push_back(exp_word(s));
  endtask

  task automatic reset_mon();
    got.delete();
    rc_count = 0;
    rc_cyc = -1;
    valid_seen = 1'b0;
    first_valid_cyc = -1;
    last_pop_cyc = -1;
  endtask

  task automatic load_cfg();
    used_channels = m_used;
    for (int c = 0; c < NC; c++)
      rx_delays[c*CW +: CW] = m_del[c][15:0];
    rx_blank = m_blank[15:0];
    num_samples = m_num[15:0];
    input_delay_data = 1'b1;
    tick();
    input_delay_data = 1'b0;
    tick();
    tick();
    check("ovf_after_load", overflow, 0);
  endtask

  task automatic start_line();
    reset_mon();
    transmit_complete = 1'b1;
    adc_valid = 1'($urandom_range(0, 1));
    adc_data = {$urandom, $urandom, $urandom};
    tc_cyc = cyc;
    tick();
    transmit_complete = 1'b0;
    adc_valid = 1'b0;
    check("rip_t1", receive_in_progress, 1);
    for (int i = 0; i < m_blank; i++) begin
      adc_valid = 1'($urandom_range(0, 1));
      adc_data = {$urandom, $urandom, $urandom};
      tick();
    end
    adc_valid = 1'b0;
  endtask

  task automatic drive_samples(input int gap_max, input int cnt);
    for (int s = 0; s < cnt; s++) begin
      for (int c = 0; c < NC; c++)
        adc_data[c*SW +: SW] = smp[s][c][11:0];
      adc_valid = 1'b1;
      if (s == 0) first_adc_cyc = cyc;
      tick();
      adc_valid = 1'b0;
      adc_data = {$urandom, $urandom, $urandom};
      repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic finish_line(input string tag);
    for (int i = 0; i < 800 && rc_count == 0; i++) tick();
    repeat (3) tick();
    check({tag, "_rc"}, rc_count, 1);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size())
        check($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic rand_cfg(input int nmax);
    m_used = 8'($urandom);
    m_num = $urandom_range(1, nmax);
    m_blank = $urandom_range(0, 4);
    for (int c = 0; c < NC; c++)
      m_del[c] = $urandom_range(0, m_num + 1);
    for (int s = 0; s < 32; s++)
      for (int c = 0; c < NC; c++)
        smp[s][c] = rnd_sample();
  endtask

  initial begin
    reset_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", aline_valid, 0);
    check("rst_last", aline_last, 0);
    check("rst_data", aline_data, 0);
    check("rst_rip", receive_in_progress, 0);
    check("rst_rc", receive_complete, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b1;
    aline_ready = 1'b1;
    tick();

    // transmit_complete while idle
    transmit_complete = 1'b1;
    tick();
    transmit_complete = 1'b0;
    repeat (4) tick();
    check("idle_tc_rip", receive_in_progress, 0);
    check("idle_tc_valid", valid_seen, 0);

    // gating: +1 everywhere, delays 0..7
    m_used = 8'hFF;
    m_blank = 3;
    m_num = 10;
    for (int c = 0; c < NC; c++) m_del[c] = c;
    for (int s = 0; s < 32; s++)
      for (int c = 0; c < NC; c++) smp[s][c] = 1;
    load_cfg();
    start_line();
    drive_samples(0, m_num);
    build_exp(99);
    finish_line("gate");
    check("gate_w0", got.size() > 0 ? got[0] : 16'hFFFF, 16'h0001);
    check("gate_w9", got.size() > 9 ? got[9] : 16'hFFFF, 16'h8008);
    check("gate_vlat", first_valid_cyc, first_adc_cyc + 2);
    check("gate_rclat", rc_cyc, last_pop_cyc + 1);

    // full-scale negative sum
    m_blank = 1;
    m_num = 6;
    for (int c = 0; c < NC; c++) m_del[c] = 0;
    for (int s = 0; s < 32; s++)
      for (int c = 0; c < NC; c++) smp[s][c] = -2048;
    load_cfg();
    start_line();
    drive_samples(2, m_num);
    build_exp(99);
    finish_line("neg");
    check("neg_w0", got.size() > 0 ? got[0] : 16'hFFFF, 16'h4000);

    // channel mask 0x05
    m_used = 8'h05;
    m_num = 8;
    for (int s = 0; s < 32; s++)
      for (int c = 0; c < NC; c++)
        smp[s][c] = (c == 0) ? 100 : (c == 2) ? -30 : rnd_sample();
    load_cfg();
    start_line();
    drive_samples(1, m_num);
    build_exp(99);
    finish_line("mask");
    check("mask_w1", got.size() > 1 ? got[1] : 16'hFFFF, 16'd70);

    // backpressure and overflow
    rand_cfg(4);
    m_used = 8'hFF;
    m_num = 20;
    m_blank = 2;
    aline_ready = 1'b0;
    load_cfg();
    start_line();
    drive_samples(1, m_num);
    build_exp(FD);
    repeat (5) tick();
    check("bp_ovf", overflow, 1);
    check("bp_valid", aline_valid, 1);
    check("bp_head", {aline_last, aline_data}, exp_q[0]);
    repeat (3) tick();
    check("bp_hold", {aline_last, aline_data}, exp_q[0]);
    check("bp_rip", receive_in_progress, 1);
    aline_ready = 1'b1;
    finish_line("bp");
    check("bp_ovf_sticky", overflow, 1);

    // zero-length A-line
    m_num = 0;
    m_blank = 0;
    load_cfg();
    start_line();
    build_exp(99);
    finish_line("zero");
    check("zero_novalid", valid_seen, 0);
    check("zero_rclat", rc_cyc, tc_cyc + 3);

    // reset in the middle of acquisition
    rand_cfg(4);
    m_num = 12;
    m_blank = 1;
    aline_ready = 1'b0;
    load_cfg();
    start_line();
    drive_samples(0, 5);
    repeat (3) tick();
    check("mid_valid", aline_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", aline_valid, 0);
    check("mid_rst_data", aline_data, 0);
    check("mid_rst_last", aline_last, 0);
    check("mid_rst_rip", receive_in_progress, 0);
    check("mid_rst_rc", receive_complete, 0);
    check("mid_rst_ovf", overflow, 0);
    tick();
    rst = 1'b1;
    aline_ready = 1'b1;
    tick();
    rand_cfg(12);
    load_cfg();
    start_line();
    drive_samples(2, m_num);
    build_exp(99);
    finish_line("post_rst");

    // randomized lines with random backpressure
    rnd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_cfg(12);
      load_cfg();
      start_line();
      drive_samples(2, m_num);
      build_exp(99);
      finish_line($sformatf("rnd%0d", k));
    end
    rnd_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
